// File: rtl/tickgen_multi.sv
// Multi-channel tick generator: NCH independent one-cycle strobes, each with a
// runtime divisor, enable, periodic/one-shot mode and a shared re-phase input.
module tickgen_multi #(
  parameter int NCH         = 4,
  parameter int CHW         = 2,
  parameter int CW          = 16,
  parameter int DEFAULT_DIV = 50
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  input  logic           cfg_mode,
  input  logic [NCH-1:0] ch_en,
  input  logic           sync,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] busy,
  output logic           tick_any
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [CW-1:0] DIV_RST = CW'(DEFAULT_DIV);
  localparam logic [CW-1:0] ONE     = CW'(1);

  state_e         state_q [NCH];
  state_e         state_d [NCH];
  logic [CW-1:0]  div_q   [NCH];
  logic [CW-1:0]  div_d   [NCH];
  logic [CW-1:0]  cnt_q   [NCH];
  logic [CW-1:0]  cnt_d   [NCH];
  logic [NCH-1:0] mode_q, mode_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] busy_q, busy_d;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      div_d[i]   = div_q[i];
      mode_d[i]  = mode_q[i];
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      tick_d[i]  = 1'b0;

      // Channel numbers >= NCH match no loop index, so such writes fall away.
      if (cfg_we && (cfg_ch == CHW'(i))) begin
        div_d[i]  = cfg_div;
        mode_d[i] = cfg_mode;
      end

      // Reloads read div_q, so a write on a reload edge only affects later reloads.
      unique case (state_q[i])
        IDLE: begin
          if (ch_en[i] && (div_q[i] != '0)) begin
            state_d[i] = RUN;
            cnt_d[i]   = div_q[i] - ONE;
          end
        end
        RUN: begin
          if (!ch_en[i]) begin
            state_d[i] = IDLE;
          end else if (sync) begin
            cnt_d[i] = div_q[i] - ONE;
          end else if (cnt_q[i] == '0) begin
            tick_d[i] = 1'b1;
            if (mode_q[i]) state_d[i] = DONE;
            else           cnt_d[i]   = div_q[i] - ONE;
          end else begin
            cnt_d[i] = cnt_q[i] - ONE;
          end
        end
        DONE: begin
          if (!ch_en[i]) state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase

      busy_d[i] = (state_d[i] == RUN);
    end
  end

  // NOTE: the per-channel arrays are control registers, not storage, so each entry is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        div_q[i]   <= DIV_RST;
        cnt_q[i]   <= '0;
      end
      mode_q <= '0;
      tick_q <= '0;
      busy_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        div_q[i]   <= div_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      mode_q <= mode_d;
      tick_q <= tick_d;
      busy_q <= busy_d;
    end
  end

  assign tick     = tick_q;
  assign busy     = busy_q;
  assign tick_any = |tick_q;

endmodule

// File: tb/tb_tickgen_multi.sv
// Directed bench for tickgen_multi: a 4-channel instance for the main behaviour
// and a 3-channel instance for the out-of-range configuration write.
module tb_tickgen_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we, cfg_we3;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        cfg_mode;
  logic [3:0]  ch_en;
  logic [2:0]  ch_en3;
  logic        sync;
  logic [3:0]  tick, busy;
  logic        tick_any;
  logic [2:0]  tick3, busy3;
  logic        tick_any3;

  int checks   = 0;
  int failures = 0;

  tickgen_multi #(.NCH(4), .CHW(2), .CW(16), .DEFAULT_DIV(50)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_mode(cfg_mode), .ch_en(ch_en), .sync(sync), .tick(tick), .busy(busy),
    .tick_any(tick_any)
  );

  tickgen_multi #(.NCH(3), .CHW(2), .CW(16), .DEFAULT_DIV(50)) dut3 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we3), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_mode(cfg_mode), .ch_en(ch_en3), .sync(1'b0), .tick(tick3), .busy(busy3),
    .tick_any(tick_any3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n edges; sampling happens 1 time unit after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Watch tick[ch] over n edges; indices are 1-based from the first watched edge.
  task automatic run_watch(input int n, input int ch, output int first,
                           output int count, output int last, output int others);
    logic [3:0] mask;
    mask   = ~(4'b0001 << ch);
    first  = -1;
    count  = 0;
    last   = -1;
    others = 0;
    for (int i = 1; i <= n; i++) begin
      step(1);
      if (tick[ch]) begin
        count++;
        if (first < 0) first = i;
        last = i;
      end
      if ((tick & mask) != 4'b0) others = 1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] dv, input logic md);
    cfg_ch   = ch;
    cfg_div  = dv;
    cfg_mode = md;
    cfg_we   = 1'b1;
    step(1);
    cfg_we   = 1'b0;
  endtask

  initial begin
    int first, count, last, others, n3_all, n3_bad, f3;

    rst = 1'b1; cfg_we = 1'b0; cfg_we3 = 1'b0; cfg_ch = '0; cfg_div = '0;
    cfg_mode = 1'b0; ch_en = '0; ch_en3 = '0; sync = 1'b0;
    step(2);
    check("rst_tick", tick, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Default divisor 50 on ch0.
    ch_en = 4'b0001;
    step(1);
    check("a_busy", busy, 4'b0001);
    run_watch(150, 0, first, count, last, others);
    check("a_first", first, 50);
    check("a_count", count, 3);
    check("a_last", last, 150);
    check("a_others", others, 0);
    ch_en = 4'b0000;
    step(1);
    check("a_off_busy", busy, 0);

    // ch1 div=3; a write of div=5 landing on a reload edge applies one period later.
    cfg_write(2'd1, 16'd3, 1'b0);
    ch_en = 4'b0010;
    step(1);
    run_watch(7, 1, first, count, last, others);
    check("b_first", first, 3);
    check("b_count", count, 2);
    check("b_last", last, 6);
    step(1);
    cfg_write(2'd1, 16'd5, 1'b0);
    check("b_tick_on_wr", tick[1], 1);
    run_watch(13, 1, first, count, last, others);
    check("b2_first", first, 3);
    check("b2_count", count, 3);
    check("b2_last", last, 13);
    ch_en = 4'b0000;
    step(1);
    check("b_off_busy", busy[1], 0);

    // ch2 one-shot div=4, then re-armed by an enable toggle.
    cfg_write(2'd2, 16'd4, 1'b1);
    ch_en = 4'b0100;
    step(1);
    run_watch(12, 2, first, count, last, others);
    check("c_first", first, 4);
    check("c_count", count, 1);
    check("c_busy_done", busy[2], 0);
    ch_en = 4'b0000;
    step(1);
    ch_en = 4'b0100;
    step(1);
    run_watch(8, 2, first, count, last, others);
    check("c2_first", first, 4);
    check("c2_count", count, 1);
    ch_en = 4'b0000;
    step(1);

    // ch3 div=1: tick stays high once started.
    cfg_write(2'd3, 16'd1, 1'b0);
    ch_en = 4'b1000;
    step(1);
    run_watch(6, 3, first, count, last, others);
    check("d1_first", first, 1);
    check("d1_count", count, 6);
    check("d1_tick_any", tick_any, 1);
    ch_en = 4'b0000;
    step(1);
    check("d1_off_tick", tick[3], 0);

    // div=0 never leaves IDLE.
    cfg_write(2'd1, 16'd0, 1'b0);
    ch_en = 4'b0010;
    step(1);
    run_watch(20, 1, first, count, last, others);
    check("d0_count", count, 0);
    check("d0_busy", busy[1], 0);
    ch_en = 4'b0000;
    step(1);

    // sync re-phase on ch0 div=10, then disable on the terminal edge.
    cfg_write(2'd0, 16'd10, 1'b0);
    ch_en = 4'b0001;
    step(1);
    run_watch(10, 0, first, count, last, others);
    check("s_first", first, 10);
    step(3);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    run_watch(10, 0, first, count, last, others);
    check("s_resync_first", first, 10);
    check("s_resync_count", count, 1);
    step(9);
    ch_en = 4'b0000;
    step(1);
    check("s_dis_tick", tick[0], 0);
    check("s_dis_busy", busy[0], 0);
    run_watch(3, 0, first, count, last, others);
    check("s_dis_count", count, 0);

    // Asynchronous reset mid-run restores the default divisor.
    cfg_write(2'd1, 16'd2, 1'b0);
    ch_en = 4'b0010;
    step(1);
    run_watch(4, 1, first, count, last, others);
    check("r_pre_count", count, 2);
    #2 rst = 1'b1;
    #1;
    check("r_async_busy", busy, 0);
    check("r_async_tick", tick, 0);
    step(1);
    rst = 1'b0;
    step(1);
    run_watch(50, 1, first, count, last, others);
    check("r_def_first", first, 50);
    check("r_def_count", count, 1);
    ch_en = 4'b0000;
    step(1);

    // Write to channel 3 of a 3-channel instance must change nothing.
    cfg_ch = 2'd3; cfg_div = 16'd2; cfg_mode = 1'b1; cfg_we3 = 1'b1;
    step(1);
    cfg_we3 = 1'b0;
    ch_en3  = 3'b111;
    step(1);
    check("i_busy", busy3, 3'b111);
    n3_all = 0; n3_bad = 0; f3 = -1;
    for (int i = 1; i <= 100; i++) begin
      step(1);
      if (tick3 == 3'b111) begin
        n3_all++;
        if (f3 < 0) f3 = i;
      end else if (tick3 != 3'b000) begin
        n3_bad++;
      end
    end
    check("i_first", f3, 50);
    check("i_count", n3_all, 2);
    check("i_partial", n3_bad, 0);
    ch_en3 = 3'b000;
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tickgen_multi.md
# tickgen_multi

Parametrised multi-channel successor to the single-output tick generator. Produces NCH independent one-cycle tick pulses, each with a runtime-programmable period, a per-channel enable, and periodic or one-shot mode. A global sync input re-phases all running channels. Sits beside the system clock and feeds strobes to timers, UART baud logic and LED/display scanners.

## Interface
- NCH, 4, number of tick channels
- CHW, 2, channel-select width; requires 2**CHW >= NCH
- CW, 16, divisor/counter width
- DEFAULT_DIV, 50, per-channel divisor after reset; must be < 2**CW

- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  config write strobe, one write per cycle
- cfg_ch  in  CHW  channel addressed by the write
- cfg_div  in  CW  new divisor (period in clk cycles)
- cfg_mode  in  1  new mode: 0 periodic, 1 one-shot
- ch_en  in  NCH  per-channel enable, level-sensitive
- sync  in  1  re-phase all RUN channels
- tick  out  NCH  registered one-cycle tick per channel
- busy  out  NCH  channel in RUN state (registered)
- tick_any  out  1  OR of tick

## Operation
- Per-channel registers: div (CW), mode (1), cnt (CW), state {IDLE, RUN, DONE}.
- Config write: on an edge with cfg_we=1 and cfg_ch<NCH, div[cfg_ch] and mode[cfg_ch] take cfg_div and cfg_mode. Writes with cfg_ch>=NCH are ignored. A write never alters cnt or state. A new div takes effect only at reload edges after the write edge. A reload on the write edge uses the old value.
- IDLE: if ch_en=1 and div!=0, go to RUN and load cnt=div-1. Otherwise stay. div=0 keeps the channel in IDLE permanently, with no ticks.
- RUN, ch_en=0: go to IDLE and hold cnt. The resume load is fresh (cnt=div-1).
- RUN, sync=1: reload cnt=div-1 with no tick that cycle. sync has priority over terminal count.
- RUN, cnt=0: assert tick for the next cycle.
  - Periodic: reload cnt=div-1.
  - One-shot: go to DONE.
- RUN, otherwise: cnt decrements.
- DONE: no ticks. Go to IDLE when ch_en=0. sync has no effect.
- busy[i] is high in RUN. tick_any is the combinational OR of the tick register.

## Timing
- Reset (asynchronous): tick=0, busy=0, all state IDLE, cnt=0, div=DEFAULT_DIV, mode=0. Outputs drop immediately on rst rise. Behaviour resumes on the first edge after rst falls.
- Enable sampled high at edge k (IDLE→RUN): the first tick is high during the cycle after edge k+div. Periodic ticks then repeat every div cycles. Each tick is exactly 1 cycle wide.
- div=1: after the first tick, tick stays high continuously while enabled.
- Disable: ch_en sampled low at edge j clears busy and tick after edge j. A tick already scheduled for the cycle after j is suppressed.
- sync at edge s: the next tick of each RUN channel is high in the cycle after edge s+div.
- Counter arithmetic is unsigned CW-bit. cnt never underflows because reload or exit happens at 0. Maximum period is 2**CW-1 cycles.
- Channels are fully independent. Simultaneous ticks on several channels are all asserted in the same cycle.

## Test plan
- Reset defaults: hold rst, release, enable ch0 at edge 0 -> tick[0] high one cycle after edges 50, 100, 150. busy[0]=1 from edge 0. Other ticks stay 0.
- Programming: write ch1 div=3, mode=0. Enable ch1 -> tick[1] one-cycle pulses every 3 cycles. Write div=5 mid-period -> the current period stays 3, then the period is 5.
- One-shot and edge divisors: ch2 div=4, mode=1 -> exactly one tick 4 cycles after enable, then busy[2]=0 with no further ticks. Toggle ch_en low/high -> one more tick. ch3 div=1 -> tick[3] constant high. div=0 -> no tick, busy stays 0.
- sync/disable: ch0 div=10 running, sync 4 cycles after a tick -> next tick 10 cycles after the sync edge. Deassert ch_en on the terminal edge -> no tick.
- Invalid write and async reset: cfg_ch=3 with NCH=3 -> no register changes. Assert rst between edges while ticking -> tick/busy go 0 before the next edge, and divisors return to 50.
